// File: rtl/tug_light_bar.sv
// Tug-of-war light bar: N-lamp bar with press detection,
// round wins, score counters, timed round hold and match-over latch.
module tug_light_bar #(
    parameter int N_LIGHTS    = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    input  logic                restart,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  leftScore,
    output logic [SCORE_W-1:0]  rightScore,
    output logic [1:0]          roundWinner,
    output logic                matchOver
);

    localparam int PW = $clog2(N_LIGHTS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0] P_MAX = PW'(N_LIGHTS - 1);
    localparam logic [PW-1:0] P_C   = PW'((N_LIGHTS - 1) / 2);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [N_LIGHTS-1:0] L_CTR = N_LIGHTS'(1) << P_C;

    typedef enum logic [1:0] {
        S_PLAY,
        S_ROUND,
        S_MATCH
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_pos;
    logic [N_LIGHTS-1:0] r_lights;
    logic [SCORE_W-1:0]  r_left;
    logic [SCORE_W-1:0]  r_right;
    logic [1:0]          r_winner;
    logic                r_match;
    logic [HW-1:0]       r_hold;
    logic                r_lq;
    logic                r_rq;

    logic                w_press_l;
    logic                w_press_r;
    logic                w_mv_l;
    logic                w_mv_r;
    logic [SCORE_W-1:0]  w_left_nx;
    logic [SCORE_W-1:0]  w_right_nx;

    assign w_press_l  = L & ~r_lq;
    assign w_press_r  = R & ~r_rq;
    assign w_mv_l     = w_press_l & ~w_press_r;
    assign w_mv_r     = w_press_r & ~w_press_l;
    assign w_left_nx  = r_left + SCORE_W'(1);
    assign w_right_nx = r_right + SCORE_W'(1);

    assign lights      = r_lights;
    assign leftScore   = r_left;
    assign rightScore  = r_right;
    assign roundWinner = r_winner;
    assign matchOver   = r_match;

    // Game FSM: key history, lamp position, scores and round/match flow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_PLAY;
            r_pos    <= P_C;
            r_lights <= L_CTR;
            r_left   <= '0;
            r_right  <= '0;
            r_winner <= 2'b00;
            r_match  <= 1'b0;
            r_hold   <= '0;
            r_lq     <= 1'b1;
            r_rq     <= 1'b1;
        end else begin
            r_lq <= L;
            r_rq <= R;
            if (restart) begin
                r_state  <= S_PLAY;
                r_pos    <= P_C;
                r_lights <= L_CTR;
                r_left   <= '0;
                r_right  <= '0;
                r_winner <= 2'b00;
                r_match  <= 1'b0;
                r_hold   <= '0;
            end else begin
                unique case (r_state)
                    S_PLAY: begin
                        if (w_mv_l && r_pos == P_MAX) begin
                            r_left   <= w_left_nx;
                            r_winner <= 2'b01;
                            r_lights <= '0;
                            r_hold   <= '0;
                            if (w_left_nx == S_WIN) begin
                                r_state <= S_MATCH;
                                r_match <= 1'b1;
                            end else begin
                                r_state <= S_ROUND;
                            end
                        end else if (w_mv_l) begin
                            r_pos    <= r_pos + PW'(1);
                            r_lights <= r_lights << 1;
                        end else if (w_mv_r && r_pos == '0) begin
                            r_right  <= w_right_nx;
                            r_winner <= 2'b10;
                            r_lights <= '0;
                            r_hold   <= '0;
                            if (w_right_nx == S_WIN) begin
                                r_state <= S_MATCH;
                                r_match <= 1'b1;
                            end else begin
                                r_state <= S_ROUND;
                            end
                        end else if (w_mv_r) begin
                            r_pos    <= r_pos - PW'(1);
                            r_lights <= r_lights >> 1;
                        end
                    end
                    S_ROUND: begin
                        if (r_hold == H_LAST) begin
                            r_state  <= S_PLAY;
                            r_pos    <= P_C;
                            r_lights <= L_CTR;
                            r_winner <= 2'b00;
                            r_hold   <= '0;
                        end else begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end
                    S_MATCH: begin
                        r_match <= 1'b1;
                    end
                    default: begin
                        r_state <= S_PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tug_light_bar.sv
// Bench for tug_light_bar: vector table, directed corner sequences
// and random play compared against an integer game model.
module tb_tug_light_bar;

    localparam int N  = 9;
    localparam int SW = 3;
    localparam int WS = 7;
    localparam int HC = 4;
    localparam int C  = (N - 1) / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          L;
    logic          R;
    logic          restart;
    logic [N-1:0]  lights;
    logic [SW-1:0] leftScore;
    logic [SW-1:0] rightScore;
    logic [1:0]    roundWinner;
    logic          matchOver;

    tug_light_bar #(
        .N_LIGHTS(N),
        .SCORE_W(SW),
        .WIN_SCORE(WS),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .L(L),
        .R(R),
        .restart(restart),
        .lights(lights),
        .leftScore(leftScore),
        .rightScore(rightScore),
        .roundWinner(roundWinner),
        .matchOver(matchOver)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_pos, m_ls, m_rs, m_rw, m_mo, m_dark;
    bit m_pl, m_pr;

    typedef struct {
        bit         kl;
        bit         kr;
        bit         krs;
        logic [N-1:0] e_lt;
        int         e_ls;
        int         e_rs;
        int         e_rw;
        int         e_mo;
    } vec_t;

    vec_t tv[15];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_pos = C; m_ls = 0; m_rs = 0; m_rw = 0; m_mo = 0; m_dark = 0;
        m_pl = 1'b1; m_pr = 1'b1;
    endfunction

    function automatic logic [N-1:0] m_lights();
        logic [N-1:0] one;
        one = 1;
        if (m_mo != 0 || m_dark > 0) return '0;
        return one << m_pos;
    endfunction

    task automatic m_step(bit l, bit r, bit rs);
        bit pl, pr;
        pl = l && !m_pl;
        pr = r && !m_pr;
        m_pl = l;
        m_pr = r;
        if (rs) begin
            m_pos = C; m_ls = 0; m_rs = 0; m_rw = 0; m_mo = 0; m_dark = 0;
            return;
        end
        if (m_mo != 0) return;
        if (m_dark > 0) begin
            m_dark--;
            if (m_dark == 0) begin
                m_pos = C;
                m_rw = 0;
            end
            return;
        end
        if (pl && !pr) begin
            if (m_pos == N - 1) begin
                m_ls++; m_rw = 1;
                if (m_ls == WS) m_mo = 1; else m_dark = HC;
            end else m_pos++;
        end else if (pr && !pl) begin
            if (m_pos == 0) begin
                m_rs++; m_rw = 2;
                if (m_rs == WS) m_mo = 1; else m_dark = HC;
            end else m_pos--;
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".lights"}, 32'(lights), 32'(m_lights()));
        chk({tag, ".lscore"}, 32'(leftScore), 32'(m_ls));
        chk({tag, ".rscore"}, 32'(rightScore), 32'(m_rs));
        chk({tag, ".winner"}, 32'(roundWinner), 32'(m_rw));
        chk({tag, ".match"}, 32'(matchOver), 32'(m_mo));
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".lights"}, 32'(lights), 32'h010);
        chk({tag, ".lscore"}, 32'(leftScore), 0);
        chk({tag, ".rscore"}, 32'(rightScore), 0);
        chk({tag, ".winner"}, 32'(roundWinner), 0);
        chk({tag, ".match"}, 32'(matchOver), 0);
    endtask

    task automatic tick(bit l, bit r, bit rs);
        L = l;
        R = r;
        restart = rs;
        @(posedge clk);
        if (!reset) m_reset();
        else m_step(l, r, rs);
        #1;
        chk_model("model");
    endtask

    initial begin
        tv[0]  = '{1, 1, 0, 9'h010, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 9'h010, 0, 0, 0, 0};
        tv[2]  = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[3]  = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[4]  = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[5]  = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[6]  = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[7]  = '{0, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[8]  = '{0, 1, 0, 9'h010, 0, 0, 0, 0};
        tv[9]  = '{0, 0, 0, 9'h010, 0, 0, 0, 0};
        tv[10] = '{1, 1, 0, 9'h010, 0, 0, 0, 0};
        tv[11] = '{0, 0, 0, 9'h010, 0, 0, 0, 0};
        tv[12] = '{1, 0, 0, 9'h020, 0, 0, 0, 0};
        tv[13] = '{1, 1, 0, 9'h010, 0, 0, 0, 0};
        tv[14] = '{0, 0, 0, 9'h010, 0, 0, 0, 0};

        reset = 1'b0;
        L = 1'bx;
        R = 1'bx;
        restart = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("rst");
        L = 1'b1;
        R = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("rst2");
        #2 reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            tick(tv[i].kl, tv[i].kr, tv[i].krs);
            chk($sformatf("vec%0d.lights", i), 32'(lights), 32'(tv[i].e_lt));
            chk($sformatf("vec%0d.ls", i), 32'(leftScore), 32'(tv[i].e_ls));
            chk($sformatf("vec%0d.rs", i), 32'(rightScore), 32'(tv[i].e_rs));
            chk($sformatf("vec%0d.rw", i), 32'(roundWinner), 32'(tv[i].e_rw));
            chk($sformatf("vec%0d.mo", i), 32'(matchOver), 32'(tv[i].e_mo));
        end

        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0);
            if (i < 4) begin
                chk("rwalk.lights", 32'(lights), 32'h010 >> (i + 1));
                tick(0, 0, 0);
            end else begin
                chk("rwin.lights", 32'(lights), 0);
                chk("rwin.rscore", 32'(rightScore), 1);
                chk("rwin.winner", 32'(roundWinner), 2);
            end
        end
        tick(0, 0, 0);
        chk("hold1.lights", 32'(lights), 0);
        tick(1, 0, 0);
        chk("hold2.lights", 32'(lights), 0);
        tick(0, 0, 0);
        chk("hold3.lights", 32'(lights), 0);
        tick(0, 0, 0);
        chk("hold_end.lights", 32'(lights), 32'h010);
        chk("hold_end.winner", 32'(roundWinner), 0);
        tick(0, 0, 0);
        chk("hold_press.lights", 32'(lights), 32'h010);

        for (int rd = 0; rd < 7; rd++) begin
            for (int p = 0; p < 5; p++) begin
                tick(1, 0, 0);
                tick(0, 0, 0);
            end
            if (rd < 6) begin
                for (int h = 0; h < 3; h++) tick(0, 0, 0);
                chk("lround.lights", 32'(lights), 32'h010);
            end
        end
        chk("match.lscore", 32'(leftScore), 7);
        chk("match.flag", 32'(matchOver), 1);
        chk("match.winner", 32'(roundWinner), 1);
        chk("match.lights", 32'(lights), 0);
        for (int i = 0; i < 10; i++) begin
            tick(bit'(i % 2), bit'((i / 2) % 2), 0);
        end
        chk("frozen.lscore", 32'(leftScore), 7);
        chk("frozen.rscore", 32'(rightScore), 1);
        chk("frozen.flag", 32'(matchOver), 1);
        tick(0, 0, 1);
        chk_reset_vals("restart");
        tick(0, 0, 0);

        for (int w = 0; w < 2; w++) begin
            for (int p = 0; p < 5; p++) begin
                tick(0, 1, 0);
                tick(0, 0, 0);
            end
            if (w == 0) begin
                for (int h = 0; h < 3; h++) tick(0, 0, 0);
            end
        end
        chk("pre_arst.rscore", 32'(rightScore), 2);
        chk("pre_arst.lights", 32'(lights), 0);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        m_reset();
        tick(1, 1, 0);
        #2 reset = 1'b1;

        for (int i = 0; i < 6000; i++) begin
            tick(($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 800) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tug_light_bar.md
Name: tug_light_bar

Overview:
- Parametrised successor to the single-cell tug-of-war light: one block owns the whole N-light bar, not one instance per lamp.
- Adds internal key edge detection, round win detection, per-player score counters, timed round hold and match-over latch.
- Sits between the synchronised key inputs (L, R, restart) and the LED bar and score displays.

Parameters:
- N_LIGHTS, 9, lamp count; odd, >= 3; center index C = (N_LIGHTS-1)/2.
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, rounds needed to win the match; 1 <= WIN_SCORE <= 2^SCORE_W-1.
- HOLD_CYCLES, 4, cycles spent in ROUND_OVER before the next round; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- L  input  1  left key level, already synchronised.
- R  input  1  right key level, already synchronised.
- restart  input  1  level; clears scores and starts a new match.
- lights  output  N_LIGHTS  bar LEDs; bit N_LIGHTS-1 = leftmost, bit 0 = rightmost.
- leftScore  output  SCORE_W  rounds won by left.
- rightScore  output  SCORE_W  rounds won by right.
- roundWinner  output  2  01 = left, 10 = right, 00 = none.
- matchOver  output  1  high while in MATCH_OVER.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed) sets:
  - state PLAY, pos=C, lights=one-hot(C);
  - scores 0, roundWinner 00, matchOver 0, hold counter 0;
  - key-history registers Lq=Rq=1, so a key held through reset release is not a press.
- Press detect: pressL = L & ~Lq, pressR = R & ~Rq. Lq/Rq update every cycle in every state.
- Effective move this cycle:
  - mvL = pressL & ~pressR; mvR = pressR & ~pressL;
  - simultaneous presses cancel, giving no move.
- Latency: a press sampled at edge k updates pos/lights at edge k. No extra pipeline stage; outputs come straight from state registers.
- lights = one-hot(pos) in PLAY, all zero in ROUND_OVER and MATCH_OVER.
- PLAY state:
  - mvL with pos < N_LIGHTS-1: pos+1.
  - mvR with pos > 0: pos-1.
  - mvL with pos = N_LIGHTS-1: leftScore+1, roundWinner=01.
  - mvR with pos = 0: rightScore+1, roundWinner=10.
  - On a win, if the new score equals WIN_SCORE, go to MATCH_OVER; otherwise go to ROUND_OVER with hold counter=0.
- ROUND_OVER state:
  - presses ignored; counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1, go to PLAY with pos=C and roundWinner=00. This gives exactly HOLD_CYCLES cycles of dark bar.
- MATCH_OVER state:
  - matchOver=1; roundWinner holds the final winner; presses ignored; scores frozen. Remains here until restart.
- restart=1, sampled at an edge in any state:
  - go to PLAY with pos=C, both scores 0, roundWinner 00, matchOver 0, counter 0;
  - takes priority over a simultaneous move or win.
- Scores never exceed WIN_SCORE, so no wrap is possible; the increment width is SCORE_W.
- Reset asserted mid-round or mid-hold aborts immediately to reset values.
- X on L/R while reset=0 must not propagate into the outputs.

Test Plan (defaults, C=4):
1. Hold reset=0 two cycles with L=R=1, release with keys still high -> lights=9'b000010000, scores 0, roundWinner 00, matchOver 0; no move after release.
2. L high for 5 cycles, then low, then one R pulse -> lights=9'b000100000 after the first edge only; returns to 9'b000010000 after the R pulse.
3. L and R rise on the same edge -> lights stay 9'b000010000; repeat with L rising one cycle before R -> one left move only.
4. Five separate R pulses from center -> pos 3,2,1,0, then rightScore=1, roundWinner=10, lights=0 for exactly 4 cycles, then lights=9'b000010000, roundWinner=00; a press during the hold has no effect.
5. Left wins 7 rounds -> after the 7th win: leftScore=7, matchOver=1, roundWinner=01, lights=0; presses ignored for 10 cycles. restart=1 for one cycle -> scores 0, matchOver 0, lights=9'b000010000.
6. Drive reset=0 between clock edges during ROUND_OVER with rightScore=2 -> all outputs reach reset values before the next rising clk edge.
